mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//   Load/store controller between the CPU MEM stage and the data RAM port
//   (re/we/addr/data/mask, combinational read, byte-addressed, little-endian).
//   Converts sized, signed/unsigned load/store requests into word-aligned RAM
//   accesses with byte-lane masks. Models RAM wait states, stalls the pipeline
//   and flags misaligned accesses.
// PARAMETERS
//   WAIT_CYCLES  1  extra cycles ram_re is held before read data is captured (0..15)
// PORTS
//   clk            in   1   clock; all state updates on posedge
//   rst            in   1   reset; synchronous, active-low
//   req_valid      in   1   MEM-stage access request; held stable until resp_valid
//   req_we         in   1   1 = store, 0 = load
//   req_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned   in   1   loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr       in   32  byte address
//   req_wdata      in   32  store data, LSB-justified
//   req_ready      out  1   1 in IDLE (request accepted this cycle)
//   stall          out  1   req_valid && !resp_valid (combinational)
//   resp_valid     out  1   one-cycle completion pulse
//   resp_rdata     out  32  extended load data; 0 for store/misaligned responses
//   resp_misalign  out  1   valid with resp_valid; 1 = misaligned/illegal size
//   ram_re         out  1   RAM read enable
//   ram_we         out  1   RAM write enable
//   ram_addr       out  32  {req_addr[31:2],2'b00}
//   ram_wdata      out  32  lane-replicated store data (RAM data_i)
//   ram_mask       out  4   byte-lane write mask
//   ram_rdata      in   32  RAM read data (RAM data_o)
// BEHAVIOUR
//   - Reset (rst==0 at posedge): state IDLE, counter 0, all outputs 0 except
//     req_ready=1. A store whose ram_we is high in the reset cycle still lands
//     (RAM is not reset). An in-flight load is dropped; no resp_valid is issued.
//   - FSM: IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP for misaligned requests.
//   - IDLE: on req_valid, check alignment (half: addr[0]!=0; word: addr[1:0]!=0;
//     size 11 is always illegal). Misaligned: go RESP with misalign=1, RAM
//     signals stay 0. Otherwise latch the request, load registered ram_* and
//     counter=WAIT_CYCLES, go ACCESS.
//   - ACCESS, store: ram_we=1 for exactly one cycle, ram_re=0, then RESP.
//   - ACCESS, load: ram_re=1, ram_we=0, mask 0. Counter!=0: decrement, stay.
//     Counter==0: capture extended ram_rdata into resp_rdata, go RESP.
//   - RESP: resp_valid=1 for one cycle, ram_* all 0, go IDLE. The next request
//     is accepted in the following IDLE cycle (one-cycle bubble by design).
//   - Latency from acceptance cycle (c0) to resp_valid: misaligned c1,
//     store c2, load c(WAIT_CYCLES+2). ram_* outputs are 0 outside ACCESS.
//   - lane = addr[1:0]. Mask: byte 4'b0001<<lane; half 4'b0011<<lane; word 4'b1111.
//   - ram_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
//   - Load extract: byte = ram_rdata[8*lane+:8], half = ram_rdata[8*lane+:16],
//     word as-is; sign-extend unless req_unsigned (ignored for word).
//   - resp_rdata and resp_misalign hold until the next response is written.
// TESTING
//   1 SW 0x100 0xDEADBEEF, then LW 0x100 (W=1) -> mask 4'hF, we for 1 cycle;
//     load resp_rdata 0xDEADBEEF, resp_valid at c3.
//   2 SB 0x103 0xA5 -> ram_addr 0x100, mask 4'b1000, ram_wdata 0xA5A5A5A5;
//     LB 0x103 -> 0xFFFFFFA5; LBU 0x103 -> 0x000000A5.
//   3 SH 0x102 0x8001 -> mask 4'b1100, ram_wdata 0x80018001;
//     LH 0x102 -> 0xFFFF8001; LHU 0x102 -> 0x00008001.
//   4 LW 0x101, SH 0x103, size 11 -> resp_valid+misalign at c1, rdata 0,
//     ram_re/ram_we never asserted.
//   5 W=0 and W=3, back-to-back loads -> stall high exactly W+2 cycles per
//     load, re high W+1 cycles, one IDLE cycle between accesses.
//   6 rst low during ACCESS of a W=3 load -> all outputs 0 next cycle, no
//     resp_valid; a following LW returns correct data.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the MEM stage and a word-wide data RAM port.
// It turns byte/half/word requests into word-aligned RAM accesses with
// byte-lane masks and replicated store data. Loads hold ram_re for
// WAIT_CYCLES+1 cycles, and the extended read data is captured at the end of
// that window. Misaligned or illegal-size requests skip the RAM and answer
// with resp_misalign set.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        ram_re,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_mask,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  state_reg;
  logic [3:0]  cnt_reg;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [1:0]  lane_reg;
  logic        ram_re_reg;
  logic        ram_we_reg;
  logic [31:0] ram_addr_reg;
  logic [31:0] ram_wdata_reg;
  logic [3:0]  ram_mask_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_misalign_reg;

  logic        misalign;
  logic [1:0]  lane_in;
  logic [3:0]  mask_in;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  assign lane_in = req_addr[1:0];

  // Alignment check on the incoming request; size 11 is never legal
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      SZ_HALF: misalign = req_addr[0];
      SZ_WORD: misalign = |req_addr[1:0];
      2'b11:   misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  // One enable bit per byte lane, derived from access size and lane offset
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
    localparam logic [1:0] LANE = 2'(gi);
    assign mask_in[gi] = (req_size == SZ_WORD) ||
                         ((req_size == SZ_BYTE) && (lane_in == LANE)) ||
                         ((req_size == SZ_HALF) &&
                          ((lane_in == LANE) || ((lane_in + 2'd1) == LANE)));
  end

  // Replicate store data across lanes so the mask alone selects the bytes
  always_comb begin
    wdata_rep = req_wdata;
    case (req_size)
      SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  // Move the addressed lane down to bit 0, then sign- or zero-extend it
  assign rdata_shifted = ram_rdata >> {lane_reg, 3'b000};

  always_comb begin
    load_data = rdata_shifted;
    case (size_reg)
      SZ_BYTE: load_data = {{24{~unsigned_reg & rdata_shifted[7]}}, rdata_shifted[7:0]};
      SZ_HALF: load_data = {{16{~unsigned_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  // Access FSM: accept in IDLE, drive the RAM in ACCESS, pulse the response in RESP
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= ST_IDLE;
      cnt_reg           <= 4'd0;
      we_reg            <= 1'b0;
      size_reg          <= 2'b00;
      unsigned_reg      <= 1'b0;
      lane_reg          <= 2'b00;
      ram_re_reg        <= 1'b0;
      ram_we_reg        <= 1'b0;
      ram_addr_reg      <= 32'd0;
      ram_wdata_reg     <= 32'd0;
      ram_mask_reg      <= 4'd0;
      resp_rdata_reg    <= 32'd0;
      resp_misalign_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            if (misalign) begin
              state_reg         <= ST_RESP;
              resp_rdata_reg    <= 32'd0;
              resp_misalign_reg <= 1'b1;
            end else begin
              state_reg     <= ST_ACCESS;
              we_reg        <= req_we;
              size_reg      <= req_size;
              unsigned_reg  <= req_unsigned;
              lane_reg      <= lane_in;
              cnt_reg       <= WAIT_INIT;
              ram_addr_reg  <= {req_addr[31:2], 2'b00};
              ram_re_reg    <= ~req_we;
              ram_we_reg    <= req_we;
              ram_mask_reg  <= req_we ? mask_in : 4'd0;
              ram_wdata_reg <= req_we ? wdata_rep : 32'd0;
            end
          end
        end
        ST_ACCESS: begin
          if (we_reg || (cnt_reg == 4'd0)) begin
            // Store completes after its single write cycle; load after the wait window
            state_reg         <= ST_RESP;
            resp_rdata_reg    <= we_reg ? 32'd0 : load_data;
            resp_misalign_reg <= 1'b0;
            ram_re_reg        <= 1'b0;
            ram_we_reg        <= 1'b0;
            ram_addr_reg      <= 32'd0;
            ram_wdata_reg     <= 32'd0;
            ram_mask_reg      <= 4'd0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = (state_reg == ST_IDLE);
  assign resp_valid    = (state_reg == ST_RESP);
  assign stall         = req_valid & ~resp_valid;
  assign resp_rdata    = resp_rdata_reg;
  assign resp_misalign = resp_misalign_reg;
  assign ram_re        = ram_re_reg;
  assign ram_we        = ram_we_reg;
  assign ram_addr      = ram_addr_reg;
  assign ram_wdata     = ram_wdata_reg;
  assign ram_mask      = ram_mask_reg;

endmodule
